pipe_stage_reg: RTL

- Parametrised, generic pipeline-boundary register for the 5-stage CPU.
- Carries an opaque payload (any packed stage struct: if_id, id_exe, exe_mem, mem_wb) between stages with a valid/ready handshake.
- Has an optional 2-entry skid buffer, so upstream ready is a registered signal (no combinational path back through stages).
- On flush or reset, it kills every entry and presents a configurable bubble value instead of a hard-wired zero opcode.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_slot.sv | 24 ++
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-boundary register: slot state encoding and
// occupancy width.
package pipe_pkg;

   localparam int unsigned OCC_W = 2;

   typedef enum logic [1:0] {
      PS_EMPTY,
      PS_HALF,
      PS_FULL
   } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One payload register with load enable and synchronous clear-to-bubble.
// Used for both the main and the skid entry of a stage register.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int unsigned          DATA_W     = 256,
   parameter logic [DATA_W-1:0]    BUBBLE_VAL = '0
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clear) begin
         q <= BUBBLE_VAL;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline-boundary register with optional two-entry skid
// buffer; flush and reset kill every entry and expose BUBBLE_VAL downstream.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned          DATA_W     = 256,
   parameter logic [DATA_W-1:0]    BUBBLE_VAL = '0,
   parameter int unsigned          SKID       = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [OCC_W-1:0]  occupancy
);

   pipe_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_q, skid_q, main_d;
   logic              main_load, skid_load, kill;
   logic              accept, consume;

   assign kill    = rst | flush;
   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (kill) begin
         state_q <= PS_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      main_load = 1'b0;
      skid_load = 1'b0;
      unique case (state_q)
         PS_EMPTY: begin
            if (accept) begin
               state_d   = PS_HALF;
               main_load = 1'b1;
            end
         end
         PS_HALF: begin
            if (accept && (consume || SKID == 0)) begin
               main_load = 1'b1;
            end else if (accept) begin
               state_d   = PS_FULL;
               skid_load = 1'b1;
            end else if (consume) begin
               state_d = PS_EMPTY;
            end
         end
         PS_FULL: begin
            if (consume) begin
               state_d   = PS_HALF;
               main_load = 1'b1;
            end
         end
         default: state_d = PS_EMPTY;
      endcase
   end

   // Only a FULL->HALF refill takes its payload from the skid entry.
   assign main_d = (state_q == PS_FULL) ? skid_q : in_data;

   always_comb begin
      out_valid = (state_q != PS_EMPTY);
      out_data  = out_valid ? main_q : BUBBLE_VAL;
      in_ready  = (SKID != 0) ? (state_q != PS_FULL) : (!out_valid || out_ready);
      unique case (state_q)
         PS_HALF: occupancy = OCC_W'(1);
         PS_FULL: occupancy = OCC_W'(2);
         default: occupancy = OCC_W'(0);
      endcase
   end

   pipe_slot #(
      .DATA_W     (DATA_W),
      .BUBBLE_VAL (BUBBLE_VAL)
   ) u_main (
      .clk   (clk),
      .clear (kill),
      .load  (main_load),
      .d     (main_d),
      .q     (main_q)
   );

   pipe_slot #(
      .DATA_W     (DATA_W),
      .BUBBLE_VAL (BUBBLE_VAL)
   ) u_skid (
      .clk   (clk),
      .clear (kill),
      .load  (skid_load),
      .d     (in_data),
      .q     (skid_q)
   );

   // A flush may legitimately retract a stalled offer.
   a_in_stable: assert property (@(posedge clk) disable iff (rst)
      (in_valid && !in_ready && !flush) |=> (!in_valid || $stable(in_data)));
   a_occ_max: assert property (@(posedge clk) occupancy <= OCC_W'(2));
   a_bubble: assert property (@(posedge clk) !out_valid |-> (out_data == BUBBLE_VAL));

endmodule
